// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner
// Turns the two raw active-low pushbuttons into clean one-cycle press pulses
// L (left, KEY[3]) and R (right, KEY[0]) for the tug-of-war light chain.
// Each key is synchronised, then debounced by its own four-state FSM; a press
// is accepted once, and a new press needs a stable release first.
// Optional build macro: KEY_TIE_CANCEL_EN -- when defined, press requests from
// both keys in the same cycle cancel each other (neither L nor R pulses).
module key_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,  // >= 2
  parameter int DEBOUNCE_CYCLES = 4   // >= 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  output logic L,
  output logic R
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  // Index 1 is the left key, index 0 the right key; converted to pressed=1.
  logic [1:0] pressed_raw;
  logic [1:0] req;

  assign pressed_raw = {~key_l_n, ~key_r_n};

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pressed_s;
    logic                   req_g;

    assign pressed_s = sync_q[SYNC_STAGES-1];
    assign req[g]    = req_g;

    // Next-state logic: synchroniser shift and debounce FSM for this key.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pressed_raw[g]};
      state_d = state_q;
      cnt_d   = cnt_q;
      req_g   = 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed_s) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_s) begin
            // Too short to be a press: drop it without a pulse.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = HELD;
            cnt_d   = '0;
            req_g   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!pressed_s) begin
            state_d = REL_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        REL_WAIT: begin
          if (pressed_s) begin
            // Release bounce: still the same press, never a second pulse.
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // State registers for this key.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (reset) begin
        // NOTE: the synchroniser is reset too, so a press straddling reset is
        // discarded and a key held through reset restarts from "not pressed".
        sync_q  <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  logic l_q, l_d;
  logic r_q, r_d;

  // Output pulse selection, including the optional same-cycle tie cancel.
  always_comb begin
    l_d = req[1];
    r_d = req[0];
`ifdef KEY_TIE_CANCEL_EN
    if (req[1] && req[0]) begin
      l_d = 1'b0;
      r_d = 1'b0;
    end
`endif
  end

  // Registered pulse outputs: one cycle wide because a request lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      l_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      l_q <= l_d;
      r_q <= r_d;
    end
  end

  assign L = l_q;
  assign R = r_q;

endmodule
